// File: rtl/proc_pkg.sv
// Shared processor constants: control-unit state codes and PC width,
// imported by the control FSM, the PC mux and the return-address stack.
package proc_pkg;

   localparam int PC_W = 8;

   typedef logic [4:0] cs_t;

   localparam cs_t CS_CALL = 5'b11100;
   localparam cs_t CS_RET  = 5'b11101;

   // Decoded stack operation for one cycle, after edge qualification of cs.
   typedef enum logic [1:0] {
      OP_IDLE,
      OP_PUSH,
      OP_POP
   } op_t;

endpackage

// File: rtl/ret_stack_if.sv
// Bundle between the control unit / PC mux (master) and the return stack (slave).
interface ret_stack_if
   import proc_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = PC_W
);

   cs_t                          cs;
   logic [AW-1:0]                pcout;
   logic [AW-1:0]                pc_ret;
   logic                         pc_load;
   logic [$clog2(DEPTH+1)-1:0]   count;
   logic                         empty;
   logic                         full;
   logic                         err_overflow;
   logic                         err_underflow;

   modport master (
      output cs, pcout,
      input  pc_ret, pc_load, count, empty, full, err_overflow, err_underflow
   );

   modport slave (
      input  cs, pcout,
      output pc_ret, pc_load, count, empty, full, err_overflow, err_underflow
   );

endinterface

// File: rtl/ret_stack_mem.sv
// Return-address storage: DEPTH x AW register file, one synchronous write
// port and one asynchronous read port, deliberately without reset.
module ret_stack_mem #(
   parameter int DEPTH = 8,
   parameter int AW    = 8,
   parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          we,
   input  logic [PW-1:0] waddr,
   input  logic [AW-1:0] wdata,
   input  logic [PW-1:0] raddr,
   output logic [AW-1:0] rdata
);

   logic [AW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/ret_stack.sv
// Return-address stack: pushes pcout on CALL entry, pops to pc_ret/pc_load on RET.
// Define RET_STACK_WRAP_EN for a circular stack that overwrites the oldest entry when full.
module ret_stack
   import proc_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = PC_W
) (
   input logic       clk,
   input logic       reset,
   ret_stack_if.slave bus
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   cs_t           cs_q;
   logic [PW-1:0] sp;
   logic [CW-1:0] count_q;
   logic [AW-1:0] pc_ret_q;
   logic [AW-1:0] rd_data;
   logic          pc_load_q;
   logic          ovf_q;
   logic          udf_q;
   logic          is_full;
   logic          is_empty;
   logic          wr_en;
   op_t           op;

   assign is_full  = (count_q == FULL_CNT);
   assign is_empty = (count_q == '0);

   // A request only fires on the first cycle cs holds its code, so a
   // control state that lingers for several cycles still moves the stack once.
   always_comb begin
      op = OP_IDLE;
      if (bus.cs == CS_CALL && cs_q != CS_CALL) begin
         op = OP_PUSH;
      end else if (bus.cs == CS_RET && cs_q != CS_RET) begin
         op = OP_POP;
      end
   end

`ifdef RET_STACK_WRAP_EN
   // When full, sp already points at the oldest entry, so writing there recycles it.
   assign wr_en = (op == OP_PUSH) && !reset;
`else
   assign wr_en = (op == OP_PUSH) && !is_full && !reset;
`endif

   ret_stack_mem #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .PW    (PW)
   ) u_mem (
      .clk   (clk),
      .we    (wr_en),
      .waddr (sp),
      .wdata (bus.pcout),
      .raddr (sp - PW'(1)),
      .rdata (rd_data)
   );

   // Pointer, occupancy, sticky flags and the registered pop result.
   always_ff @(posedge clk) begin
      if (reset) begin
         cs_q      <= '0;
         sp        <= '0;
         count_q   <= '0;
         pc_ret_q  <= '0;
         pc_load_q <= 1'b0;
         ovf_q     <= 1'b0;
         udf_q     <= 1'b0;
      end else begin
         cs_q      <= bus.cs;
         pc_load_q <= 1'b0;
         case (op)
            OP_PUSH: begin
               if (!is_full) begin
                  sp      <= sp + PW'(1);
                  count_q <= count_q + CW'(1);
               end else begin
`ifdef RET_STACK_WRAP_EN
                  sp      <= sp + PW'(1);
`else
                  ovf_q   <= 1'b1;
`endif
               end
            end
            OP_POP: begin
               if (!is_empty) begin
                  sp        <= sp - PW'(1);
                  count_q   <= count_q - CW'(1);
                  pc_ret_q  <= rd_data;
                  pc_load_q <= 1'b1;
               end else begin
                  udf_q     <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.pc_ret        = pc_ret_q;
   assign bus.pc_load       = pc_load_q;
   assign bus.count         = count_q;
   assign bus.empty         = is_empty;
   assign bus.full          = is_full;
   assign bus.err_overflow  = ovf_q;
   assign bus.err_underflow = udf_q;

endmodule

// File: tb/tb_ret_stack.sv
// Randomized scoreboard bench for ret_stack against a queue-based LIFO model.
// Follows RET_STACK_WRAP_EN in the same way as the design.
module tb_ret_stack;
   import proc_pkg::*;

   localparam int DEPTH = 4;
   localparam int AW    = 8;

   logic clk;
   logic reset;

   ret_stack_if #(.DEPTH(DEPTH), .AW(AW)) bus ();

   ret_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int nChecks = 0;
   int nFails  = 0;

   logic [AW-1:0] stackModel [$];
   logic [AW-1:0] expQ       [$];
   cs_t           prevCs;
   logic          modelOvf;
   logic          modelUdf;
   logic          modelLoad;
   logic [AW-1:0] modelRet;

   task automatic check(input string name, input int actual, input int expected);
      nChecks++;
      if (actual != expected) begin
         nFails++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Monitor: every pc_load strobe must match the oldest outstanding expected pop.
   always @(negedge clk) begin
      if (bus.pc_load === 1'b1) begin
         if (expQ.size() == 0) begin
            check("unexpected_pc_load", 1, 0);
         end else begin
            check("pc_ret_on_load", int'(bus.pc_ret), int'(expQ.pop_front()));
         end
      end
   end

   task automatic modelStep(input cs_t c, input logic [AW-1:0] pc, input logic rst);
      modelLoad = 1'b0;
      if (rst) begin
         stackModel.delete();
         prevCs   = '0;
         modelOvf = 1'b0;
         modelUdf = 1'b0;
         modelRet = '0;
      end else begin
         if (c == CS_CALL && prevCs != CS_CALL) begin
            if (stackModel.size() < DEPTH) begin
               stackModel.push_back(pc);
            end else begin
`ifdef RET_STACK_WRAP_EN
               void'(stackModel.pop_front());
               stackModel.push_back(pc);
`else
               modelOvf = 1'b1;
`endif
            end
         end else if (c == CS_RET && prevCs != CS_RET) begin
            if (stackModel.size() > 0) begin
               modelRet  = stackModel.pop_back();
               modelLoad = 1'b1;
               expQ.push_back(modelRet);
            end else begin
               modelUdf = 1'b1;
            end
         end
         prevCs = c;
      end
   endtask

   task automatic checkOutput();
      check("count", int'(bus.count), stackModel.size());
      check("empty", int'(bus.empty), int'(stackModel.size() == 0));
      check("full", int'(bus.full), int'(stackModel.size() == DEPTH));
      check("err_overflow", int'(bus.err_overflow), int'(modelOvf));
      check("err_underflow", int'(bus.err_underflow), int'(modelUdf));
      check("pc_load", int'(bus.pc_load), int'(modelLoad));
      check("pc_ret", int'(bus.pc_ret), int'(modelRet));
   endtask

   // Inputs change 1 time unit after a rising edge; state is checked 1 unit after the next one.
   task automatic applyStimulus(input cs_t c, input logic [AW-1:0] pc, input logic rst);
      bus.cs    = c;
      bus.pcout = pc;
      reset     = rst;
      @(posedge clk);
      #1;
      modelStep(c, pc, rst);
      checkOutput();
   endtask

   initial begin
      cs_t c;
      logic [AW-1:0] ovfVals [5];
      bus.cs    = '0;
      bus.pcout = '0;
      reset     = 1'b1;
      prevCs    = '0;
      modelOvf  = 1'b0;
      modelUdf  = 1'b0;
      modelLoad = 1'b0;
      modelRet  = '0;
      @(posedge clk);
      #1;

      applyStimulus(5'd0, 8'h00, 1'b1);
      applyStimulus(5'd0, 8'h00, 1'b0);
      applyStimulus(5'd3, 8'h00, 1'b0);

      applyStimulus(CS_CALL, 8'h10, 1'b0);
      applyStimulus(5'd0,    8'h00, 1'b0);
      applyStimulus(CS_CALL, 8'h20, 1'b0);
      applyStimulus(5'd0,    8'h00, 1'b0);
      applyStimulus(CS_CALL, 8'h30, 1'b0);
      applyStimulus(CS_RET,  8'h00, 1'b0);
      applyStimulus(5'd0,    8'h00, 1'b0);
      applyStimulus(CS_RET,  8'h00, 1'b0);
      applyStimulus(5'd0,    8'h00, 1'b0);
      applyStimulus(CS_RET,  8'h00, 1'b0);
      applyStimulus(5'd0,    8'h00, 1'b0);

      for (int i = 0; i < 4; i++) applyStimulus(CS_CALL, 8'h42, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(CS_RET, 8'h00, 1'b0);
      applyStimulus(5'd0, 8'h00, 1'b0);

      applyStimulus(CS_RET, 8'h00, 1'b0);
      applyStimulus(5'd0,   8'h00, 1'b0);
      applyStimulus(CS_RET, 8'h00, 1'b0);

      applyStimulus(5'd0, 8'h00, 1'b1);
      ovfVals = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      foreach (ovfVals[i]) begin
         applyStimulus(CS_CALL, ovfVals[i], 1'b0);
         applyStimulus(5'd0, 8'h00, 1'b0);
      end
      for (int i = 0; i < 5; i++) begin
         applyStimulus(CS_RET, 8'h00, 1'b0);
         applyStimulus(5'd0, 8'h00, 1'b0);
      end

      applyStimulus(5'd0,    8'h00, 1'b1);
      applyStimulus(CS_CALL, 8'hAA, 1'b0);
      applyStimulus(CS_RET,  8'h00, 1'b1);
      applyStimulus(5'd0,    8'h00, 1'b0);

      // Call immediately followed by return, then return immediately followed by call.
      applyStimulus(CS_CALL, 8'h5C, 1'b0);
      applyStimulus(CS_RET,  8'h00, 1'b0);
      applyStimulus(CS_CALL, 8'h6D, 1'b0);
      applyStimulus(CS_RET,  8'h00, 1'b0);
      applyStimulus(CS_CALL, 8'h7E, 1'b0);
      applyStimulus(5'd0,    8'h00, 1'b0);

      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3: c = CS_CALL;
            4, 5, 6, 7: c = CS_RET;
            8:          c = 5'd0;
            default:    c = cs_t'($urandom_range(0, 31));
         endcase
         applyStimulus(c, AW'($urandom_range(0, 255)), ($urandom_range(0, 59) == 0));
      end

      applyStimulus(5'd0, 8'h00, 1'b0);
      @(negedge clk);
      check("pending_expected_pops", expQ.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
